// File: rtl/settings_frame_collector.sv
`default_nettype none
// ============================================================================
// Module   : settings_frame_collector
// Brief    : Gathers a 5-byte settings frame (cmd + int32 LE) from the UART
//            byte stream, launches the settings data handler and tracks it.
// Option   : define SETTINGS_RX_TIMEOUT_EN to build the inter-byte timeout.
// Revision : 1.0 - initial release
// ============================================================================
module settings_frame_collector #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       handler_start,
  input  logic       handler_busy,
  input  logic       handler_done,
  input  logic [2:0] buf_rd_addr,
  output logic [7:0] buf_rd_data,
  output logic       busy,
  output logic       frame_ok,
  output logic       frame_fail,
  output logic       rx_drop,
  output logic       rx_timeout
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COLLECT   = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t     state_q;
  logic [2:0] byte_cnt_q;
  logic [7:0] buf_q [0:4];
  logic       done_seen_q;
  logic       handler_start_q;
  logic       frame_ok_q;
  logic       frame_fail_q;
  logic       rx_drop_q;

`ifdef SETTINGS_RX_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] c_TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] tmo_cnt_q;
  logic                 rx_timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      byte_cnt_q      <= 3'd0;
      done_seen_q     <= 1'b0;
      handler_start_q <= 1'b0;
      frame_ok_q      <= 1'b0;
      frame_fail_q    <= 1'b0;
      rx_drop_q       <= 1'b0;
      for (int i = 0; i < 5; i++) buf_q[i] <= 8'h00;
`ifdef SETTINGS_RX_TIMEOUT_EN
      tmo_cnt_q       <= '0;
      rx_timeout_q    <= 1'b0;
`endif
    end else begin
      handler_start_q <= 1'b0;
      frame_ok_q      <= 1'b0;
      frame_fail_q    <= 1'b0;
      // A frame is in flight: further bytes are discarded, not buffered
      rx_drop_q       <= rx_valid && (state_q inside {S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE});
`ifdef SETTINGS_RX_TIMEOUT_EN
      rx_timeout_q    <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            buf_q[0]   <= rx_data;
            byte_cnt_q <= 3'd1;
            state_q    <= S_COLLECT;
`ifdef SETTINGS_RX_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
          end
        end
        S_COLLECT: begin
          if (rx_valid) begin
            buf_q[byte_cnt_q] <= rx_data;
`ifdef SETTINGS_RX_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
            if (byte_cnt_q == 3'd4) begin
              byte_cnt_q      <= 3'd0;
              done_seen_q     <= 1'b0;
              handler_start_q <= 1'b1;
              state_q         <= S_LAUNCH;
            end else begin
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end
`ifdef SETTINGS_RX_TIMEOUT_EN
          else if (tmo_cnt_q == c_TMO_LAST) begin
            rx_timeout_q <= 1'b1;
            byte_cnt_q   <= 3'd0;
            tmo_cnt_q    <= '0;
            state_q      <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TIMEOUT_W'(1);
          end
`endif
        end
        S_LAUNCH: state_q <= S_WAIT_ACK;
        S_WAIT_ACK: begin
          // Busy still low here means the handler ignored the start
          if (handler_busy) begin
            state_q <= S_WAIT_DONE;
          end else begin
            frame_fail_q <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        S_WAIT_DONE: begin
          if (!handler_busy) begin
            frame_ok_q   <= done_seen_q | handler_done;
            frame_fail_q <= ~(done_seen_q | handler_done);
            state_q      <= S_IDLE;
          end else if (handler_done) begin
            done_seen_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    buf_rd_data = 8'h00;
    if (buf_rd_addr <= 3'd4) buf_rd_data = buf_q[buf_rd_addr];
  end

  assign busy          = (state_q != S_IDLE);
  assign handler_start = handler_start_q;
  assign frame_ok      = frame_ok_q;
  assign frame_fail    = frame_fail_q;
  assign rx_drop       = rx_drop_q;
`ifdef SETTINGS_RX_TIMEOUT_EN
  assign rx_timeout    = rx_timeout_q;
`else
  assign rx_timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_settings_frame_collector.sv
`default_nettype none
// Bench for settings_frame_collector: status pulses are checked through an
// event scoreboard, buffer contents and control outputs inline per scenario.
module tb_settings_frame_collector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       handler_busy = 1'b0;
  logic       handler_done = 1'b0;
  logic [2:0] buf_rd_addr = 3'd0;
  logic       handler_start, busy, frame_ok, frame_fail, rx_drop, rx_timeout;
  logic [7:0] buf_rd_data;

  always #5 clk = ~clk;

  settings_frame_collector #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .handler_start(handler_start),
    .handler_busy (handler_busy),
    .handler_done (handler_done),
    .buf_rd_addr  (buf_rd_addr),
    .buf_rd_data  (buf_rd_data),
    .busy         (busy),
    .frame_ok     (frame_ok),
    .frame_fail   (frame_fail),
    .rx_drop      (rx_drop),
    .rx_timeout   (rx_timeout)
  );

  localparam logic [3:0] EV_OK   = 4'b0001;
  localparam logic [3:0] EV_FAIL = 4'b0010;
  localparam logic [3:0] EV_DROP = 4'b0100;
  localparam logic [3:0] EV_TMO  = 4'b1000;

  int         tests = 0;
  int         fails = 0;
  logic [3:0] exp_q [$];
  logic [7:0] exp_buf [0:4];
  logic [3:0] mon_ev, mon_exp;
  logic [7:0] rd_exp;

  // Scoreboard: every status pulse must match the next expected event
  always @(negedge clk) begin
    mon_ev = {rx_timeout, rx_drop, frame_fail, frame_ok};
    if (!rst && mon_ev !== 4'b0000) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL event_unexpected got=%b expected=none", mon_ev);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_ev !== mon_exp) begin
          fails++;
          $display("FAIL event_order got=%b expected=%b", mon_ev, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int idx);
    rx_valid = 1'b1;
    rx_data  = b;
    if (idx >= 0 && idx < 5) exp_buf[idx] = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 0; i < 5; i++) send_byte(f[8*i +: 8], i);
  endtask

  // Handler model, entered in the cycle handler_start should be high.
  // mode 0: done before busy falls; 1: no done; 2: start ignored; 3: done with busy fall
  task automatic handle(input int mode, input int n);
    exp_q.push_back((mode == 0 || mode == 3) ? EV_OK : EV_FAIL);
    tests++;
    if (handler_start !== 1'b1) begin
      fails++; $display("FAIL start_high got=%b expected=1", handler_start);
    end
    if (mode != 2) handler_busy = 1'b1;
    tick();
    tests++;
    if (handler_start !== 1'b0) begin
      fails++; $display("FAIL start_one_cycle got=%b expected=0", handler_start);
    end
    if (mode == 0) begin
      repeat (n - 1) tick();
      handler_done = 1'b1;
      tick();
      handler_done = 1'b0;
      handler_busy = 1'b0;
      tick();
    end else if (mode == 1) begin
      repeat (n) tick();
      handler_busy = 1'b0;
      tick();
    end else if (mode == 3) begin
      repeat (n) tick();
      handler_busy = 1'b0;
      handler_done = 1'b1;
      tick();
      handler_done = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_missing_event got=none expected=%b", name, exp_q[0]);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    tick();
    tests++;
    if ({busy, handler_start, frame_ok, frame_fail, rx_drop, rx_timeout} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs got=%b expected=000000",
               {busy, handler_start, frame_ok, frame_fail, rx_drop, rx_timeout});
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) exp_buf[i] = 8'h00;
    for (int a = 0; a < 8; a++) begin
      buf_rd_addr = 3'(a);
      @(negedge clk);
      tests++;
      if (buf_rd_data !== 8'h00) begin
        fails++; $display("FAIL reset_buf[%0d] got=%h expected=00", a, buf_rd_data);
      end
    end
    tick();
  endtask

  task automatic test_frame_ok();
    send_frame(40'h00_00_00_10_01);
    handle(0, 7);
    wait_drain("frame_ok");
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL ok_busy_after got=%b expected=0", busy); end
    for (int a = 0; a < 8; a++) begin
      buf_rd_addr = 3'(a);
      rd_exp = (a < 5) ? exp_buf[a] : 8'h00;
      @(negedge clk);
      tests++;
      if (buf_rd_data !== rd_exp) begin
        fails++; $display("FAIL ok_buf[%0d] got=%h expected=%h", a, buf_rd_data, rd_exp);
      end
    end
    tick();
  endtask

  task automatic test_frame_reject();
    send_frame(40'h00_00_00_40_01);
    handle(1, 4);
    wait_drain("reject");
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reject_busy got=%b expected=0", busy); end
  endtask

  task automatic test_start_ignored();
    send_frame(40'h78_56_34_12_02);
    handle(2, 0);
    wait_drain("ignored");
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL ignored_busy got=%b expected=0", busy); end
  endtask

  task automatic test_drop();
    send_frame(40'hEF_BE_AD_DE_03);
    tests++;
    if (handler_start !== 1'b1) begin fails++; $display("FAIL drop_start got=%b expected=1", handler_start); end
    handler_busy = 1'b1;
    repeat (3) tick();
    exp_q.push_back(EV_DROP);
    send_byte(8'hAA, -1);
    repeat (3) tick();
    exp_q.push_back(EV_OK);
    handler_done = 1'b1;
    tick();
    handler_done = 1'b0;
    handler_busy = 1'b0;
    tick();
    wait_drain("drop");
    for (int a = 0; a < 5; a++) begin
      buf_rd_addr = 3'(a);
      @(negedge clk);
      tests++;
      if (buf_rd_data !== exp_buf[a]) begin
        fails++; $display("FAIL drop_buf[%0d] got=%h expected=%h", a, buf_rd_data, exp_buf[a]);
      end
    end
    tick();
    send_frame(40'h05_04_03_02_04);
    handle(0, 5);
    wait_drain("after_drop");
    for (int a = 0; a < 5; a++) begin
      buf_rd_addr = 3'(a);
      @(negedge clk);
      tests++;
      if (buf_rd_data !== exp_buf[a]) begin
        fails++; $display("FAIL next_buf[%0d] got=%h expected=%h", a, buf_rd_data, exp_buf[a]);
      end
    end
    tick();
  endtask

  task automatic test_timeout();
`ifdef SETTINGS_RX_TIMEOUT_EN
    send_byte(8'h11, 0);
    send_byte(8'h22, 1);
    exp_q.push_back(EV_TMO);
    repeat (15) tick();
    tests++;
    if ({busy, rx_timeout} !== 2'b10) begin
      fails++; $display("FAIL tmo_early got=%b expected=10", {busy, rx_timeout});
    end
    tick();
    tests++;
    if ({busy, rx_timeout} !== 2'b01) begin
      fails++; $display("FAIL tmo_expire got=%b expected=01", {busy, rx_timeout});
    end
    wait_drain("timeout");
    send_frame(40'h0D_0C_0B_0A_05);
    handle(0, 3);
    wait_drain("tmo_fresh");
    send_byte(8'h21, 0);
    send_byte(8'h32, 1);
    repeat (15) tick();
    send_byte(8'h43, 2);
    send_byte(8'h54, 3);
    send_byte(8'h65, 4);
`else
    send_byte(8'h21, 0);
    send_byte(8'h32, 1);
    repeat (40) tick();
    tests++;
    if ({busy, rx_timeout} !== 2'b10) begin
      fails++; $display("FAIL no_tmo_wait got=%b expected=10", {busy, rx_timeout});
    end
    send_byte(8'h43, 2);
    send_byte(8'h54, 3);
    send_byte(8'h65, 4);
`endif
    handle(0, 3);
    wait_drain("tmo_edge");
    for (int a = 0; a < 5; a++) begin
      buf_rd_addr = 3'(a);
      @(negedge clk);
      tests++;
      if (buf_rd_data !== exp_buf[a]) begin
        fails++; $display("FAIL tmo_buf[%0d] got=%h expected=%h", a, buf_rd_data, exp_buf[a]);
      end
    end
    tick();
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        send_byte(8'h91, 0); send_byte(8'h92, 1); send_byte(8'h93, 2);
      end else begin
        send_frame(40'h99_98_97_96_95);
        handler_busy = 1'b1;
        repeat (4) tick();
      end
      rst = 1'b1;
      handler_busy = 1'b0;
      tick();
      rst = 1'b0;
      tests++;
      if ({busy, handler_start, frame_ok, frame_fail, rx_drop, rx_timeout} !== 6'b0) begin
        fails++;
        $display("FAIL midrst%0d_outputs got=%b expected=000000", k,
                 {busy, handler_start, frame_ok, frame_fail, rx_drop, rx_timeout});
      end
      for (int a = 0; a < 8; a++) begin
        buf_rd_addr = 3'(a);
        @(negedge clk);
        tests++;
        if (buf_rd_data !== 8'h00) begin
          fails++; $display("FAIL midrst%0d_buf[%0d] got=%h expected=00", k, a, buf_rd_data);
        end
      end
      tick();
      send_frame(40'hA5_A4_A3_A2_A1 + 40'(k));
      handle(0, 7);
      wait_drain("midrst");
      for (int a = 0; a < 5; a++) begin
        buf_rd_addr = 3'(a);
        @(negedge clk);
        tests++;
        if (buf_rd_data !== exp_buf[a]) begin
          fails++; $display("FAIL midrst%0d_next[%0d] got=%h expected=%h", k, a, buf_rd_data, exp_buf[a]);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    send_frame(40'h44_33_22_11_06);
    handle(3, 4);
    // state has just returned to IDLE: this byte must open the next frame
    send_byte(8'h07, 0);
    send_byte(8'h81, 1);
    send_byte(8'h82, 2);
    send_byte(8'h83, 3);
    send_byte(8'h84, 4);
    handle(2, 0);
    wait_drain("b2b");
    for (int a = 0; a < 5; a++) begin
      buf_rd_addr = 3'(a);
      @(negedge clk);
      tests++;
      if (buf_rd_data !== exp_buf[a]) begin
        fails++; $display("FAIL b2b_buf[%0d] got=%h expected=%h", a, buf_rd_data, exp_buf[a]);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_frame_ok();
    test_frame_reject();
    test_start_ignored();
    test_drop();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
